// File: rtl/blossom_pkg.sv
// Shared widths, FSM encodings and LFSR helpers for the blossom sprite scheduler.
package blossom_pkg;

  localparam int COORD_W    = 10;
  localparam int CELL_SHIFT = 5;
  localparam int TIMER_W    = 5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_UPDATE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/blossom_lfsr.sv
// 16-bit Galois LFSR that advances only when step is high; exposes the low bits used for placement.
module blossom_lfsr
  import blossom_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [4:0] rnd
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= SEED;
    else if (step) state <= lfsr_next(state);
  end

  assign rnd = state[4:0];

endmodule

// File: rtl/blossom_scheduler.sv
// Once-per-frame sequential pass over the blossom slots: click hits, falling, despawn and timed respawn.
//   state  | meaning
//   IDLE   | waiting for frame_start; click edges accumulate in click_pending
//   UPDATE | one slot per cycle (slot idx), LFSR steps every cycle
//   DONE   | single cycle after the last slot, then back to IDLE
module blossom_scheduler
  import blossom_pkg::*;
#(
  parameter int          N_SLOTS   = 8,
  parameter int          X_LEFT    = 300,
  parameter int          Y_TOP     = 240,
  parameter int          Y_BOTTOM  = 480,
  parameter int          SPEED     = 1,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         click,
  input  logic [3:0]                   mouse_x,
  input  logic [3:0]                   mouse_y,
  output logic [COORD_W*N_SLOTS-1:0]   blossom_x,
  output logic [COORD_W*N_SLOTS-1:0]   blossom_y,
  output logic [N_SLOTS-1:0]           active,
  output logic                         busy,
  output logic [7:0]                   hit_count
);

  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  localparam logic [COORD_W-1:0] X_L   = COORD_W'(X_LEFT);
  localparam logic [COORD_W-1:0] Y_T   = COORD_W'(Y_TOP);
  localparam logic [COORD_W-1:0] SPD   = COORD_W'(SPEED);
  localparam logic [COORD_W:0]   SPD_W = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0]   Y_B_W = (COORD_W+1)'(Y_BOTTOM);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               busy_q;
  logic [2:0]         click_sync;
  logic               click_edge;
  logic               click_pending;
  logic               click_frame;
  logic [3:0]         mouse_x_l;
  logic [3:0]         mouse_y_l;
  logic [7:0]         hit_q;
  logic [4:0]         rnd;

  logic [COORD_W-1:0] x_q [N_SLOTS];
  logic [COORD_W-1:0] y_q [N_SLOTS];
  logic [TIMER_W-1:0] t_q [N_SLOTS];
  logic [N_SLOTS-1:0] act_q;

  logic [N_SLOTS-1:0] slot_hit;
  logic [N_SLOTS-1:0] slot_fall_done;
  logic               cur_hit;
  logic [TIMER_W-1:0] respawn_t;
  logic               updating;

  blossom_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (updating),
    .rnd   (rnd)
  );

  assign updating   = (state == ST_UPDATE);
  assign click_edge = click_sync[1] & ~click_sync[2];
  assign respawn_t  = TIMER_W'(rnd[3:0]) + TIMER_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) click_sync <= '0;
    else        click_sync <= {click_sync[1:0], click};
  end

  // Bit 9 set means off the 16x16 cell grid, so such a slot can never be hit.
  always_comb begin
    slot_hit       = '0;
    slot_fall_done = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_hit[i] = act_q[i] & click_frame &
                    ~x_q[i][COORD_W-1] & ~y_q[i][COORD_W-1] &
                    (x_q[i][CELL_SHIFT +: 4] == mouse_x_l) &
                    (y_q[i][CELL_SHIFT +: 4] == mouse_y_l);
      slot_fall_done[i] = ({1'b0, y_q[i]} + SPD_W) >= Y_B_W;
    end
  end

  assign cur_hit = slot_hit[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      busy_q        <= 1'b0;
      click_pending <= 1'b0;
      click_frame   <= 1'b0;
      mouse_x_l     <= '0;
      mouse_y_l     <= '0;
    end else begin
      if (state == ST_IDLE && frame_start) click_pending <= click_edge;
      else if (click_edge)                 click_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            click_frame <= click_pending;
            mouse_x_l   <= mouse_x;
            mouse_y_l   <= mouse_y;
            idx         <= '0;
            busy_q      <= 1'b1;
            state       <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (idx == IDX_W'(N_SLOTS - 1)) state <= ST_DONE;
          else                            idx   <= idx + 1'b1;
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  hit_q <= '0;
    else if (updating && cur_hit && hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i] <= X_L + COORD_W'(4 * i);
        y_q[i] <= Y_T;
        t_q[i] <= TIMER_W'(i + 1);
      end
    end else if (updating) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (idx == IDX_W'(i)) begin
          if (slot_hit[i]) begin
            act_q[i] <= 1'b0;
            t_q[i]   <= respawn_t;
          end else if (act_q[i]) begin
            if (slot_fall_done[i]) begin
              act_q[i] <= 1'b0;
              y_q[i]   <= Y_T;
              t_q[i]   <= respawn_t;
            end else begin
              y_q[i] <= y_q[i] + SPD;
            end
          end else if (t_q[i] > TIMER_W'(1)) begin
            t_q[i] <= t_q[i] - TIMER_W'(1);
          end else if (t_q[i] == TIMER_W'(1)) begin
            act_q[i] <= 1'b1;
            y_q[i]   <= Y_T;
            x_q[i]   <= X_L + COORD_W'(rnd);
            t_q[i]   <= '0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign blossom_x[COORD_W*g +: COORD_W] = x_q[g];
    assign blossom_y[COORD_W*g +: COORD_W] = y_q[g];
  end

  assign active    = act_q;
  assign busy      = busy_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_blossom_scheduler.sv
// Directed bench for blossom_scheduler: vector table for the spawn stagger, hand sequences for hits, falls and reset.
module tb_blossom_scheduler;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          click;
  logic [3:0]    mouse_x;
  logic [3:0]    mouse_y;
  logic [10*N-1:0] blossom_x;
  logic [10*N-1:0] blossom_y;
  logic [N-1:0]  active;
  logic          busy;
  logic [7:0]    hit_count;

  int n_cmp = 0;
  int n_bad = 0;

  blossom_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .click       (click),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .blossom_x   (blossom_x),
    .blossom_y   (blossom_y),
    .active      (active),
    .busy        (busy),
    .hit_count   (hit_count)
  );

  always #5 clk = ~clk;

  // frame-level reference model
  logic [9:0]  m_x [N];
  logic [9:0]  m_y [N];
  logic [4:0]  m_t [N];
  logic [7:0]  m_a;
  logic [15:0] m_lfsr;
  int          m_hits;
  bit          carry_click;

  typedef struct {
    bit         clk_in;
    logic [3:0] mx;
    logic [3:0] my;
    logic [7:0] exp_active;
    logic [9:0] exp_y0;
    logic [7:0] exp_hit;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 10'(300 + 4 * i);
      m_y[i] = 10'd240;
      m_t[i] = 5'(i + 1);
    end
    m_a         = '0;
    m_lfsr      = 16'hACE1;
    m_hits      = 0;
    carry_click = 1'b0;
  endtask

  task automatic model_frame(input bit clicked, input logic [3:0] cx, input logic [3:0] cy);
    for (int i = 0; i < N; i++) begin
      if (m_a[i] && clicked && int'(m_x[i]) < 512 && int'(m_y[i]) < 512 &&
          int'(m_x[i]) / 32 == int'(cx) && int'(m_y[i]) / 32 == int'(cy)) begin
        m_a[i] = 1'b0;
        m_t[i] = 5'(int'(m_lfsr) % 16 + 1);
        m_hits++;
      end else if (m_a[i]) begin
        if (int'(m_y[i]) + 1 >= 480) begin
          m_a[i] = 1'b0;
          m_y[i] = 10'd240;
          m_t[i] = 5'(int'(m_lfsr) % 16 + 1);
        end else begin
          m_y[i] = m_y[i] + 10'd1;
        end
      end else if (m_t[i] > 5'd1) begin
        m_t[i] = m_t[i] - 5'd1;
      end else if (m_t[i] == 5'd1) begin
        m_a[i] = 1'b1;
        m_y[i] = 10'd240;
        m_x[i] = 10'(300 + int'(m_lfsr) % 32);
        m_t[i] = 5'd0;
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
  endtask

  task automatic check_model(input string tag);
    logic [79:0] ex;
    logic [79:0] ey;
    ex = '0;
    ey = '0;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10] = m_x[i];
      ey[10*i +: 10] = m_y[i];
    end
    check({tag, "_active"}, 80'(active), 80'(m_a));
    check({tag, "_hits"}, 80'(hit_count), 80'((m_hits > 255) ? 255 : m_hits));
    check({tag, "_x"}, blossom_x, ex);
    check({tag, "_y"}, blossom_y, ey);
  endtask

  task automatic run_frame(input bit do_click, input logic [3:0] cx, input logic [3:0] cy,
                           input bit extra_fs, input bit mid_click);
    int cnt;
    int guard;
    bit model_click;
    mouse_x = cx;
    mouse_y = cy;
    if (do_click) begin
      @(negedge clk) click = 1'b1;
      repeat (2) @(negedge clk);
      click = 1'b0;
      repeat (4) @(negedge clk);
    end
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    cnt   = 0;
    guard = 0;
    while (busy && guard < 50) begin
      cnt++;
      frame_start = (extra_fs && cnt == 3);
      if (mid_click && cnt == 2) click = 1'b1;
      if (mid_click && cnt == 4) click = 1'b0;
      @(negedge clk);
      guard++;
    end
    frame_start = 1'b0;
    check("busy_len", 80'(cnt), 80'(N + 1));
    if (extra_fs) begin
      repeat (3) @(negedge clk);
      check("no_requeue_busy", 80'(busy), 80'(0));
    end
    @(negedge clk);
    model_click = do_click | carry_click;
    carry_click = mid_click;
    model_frame(model_click, cx, cy);
    check_model("frame");
  endtask

  task automatic check_reset_state(input string tag);
    logic [79:0] ex;
    logic [79:0] ey;
    for (int i = 0; i < N; i++) begin
      ex[10*i +: 10] = 10'(300 + 4 * i);
      ey[10*i +: 10] = 10'd240;
    end
    check({tag, "_active"}, 80'(active), 80'(0));
    check({tag, "_hits"}, 80'(hit_count), 80'(0));
    check({tag, "_busy"}, 80'(busy), 80'(0));
    check({tag, "_x"}, blossom_x, ex);
    check({tag, "_y"}, blossom_y, ey);
  endtask

  initial begin
    logic [3:0] cx;
    logic [3:0] cy;
    int         wait_f;
    int         f;

    tbl[0] = '{1'b0, 4'd0,  4'd0,  8'h01, 10'd240, 8'd0};
    tbl[1] = '{1'b0, 4'd0,  4'd0,  8'h03, 10'd241, 8'd0};
    tbl[2] = '{1'b0, 4'd9,  4'd7,  8'h07, 10'd242, 8'd0};
    tbl[3] = '{1'b1, 4'd0,  4'd0,  8'h0F, 10'd243, 8'd0};
    tbl[4] = '{1'b0, 4'd3,  4'd3,  8'h1F, 10'd244, 8'd0};
    tbl[5] = '{1'b1, 4'd15, 4'd15, 8'h3F, 10'd245, 8'd0};
    tbl[6] = '{1'b0, 4'd0,  4'd0,  8'h7F, 10'd246, 8'd0};
    tbl[7] = '{1'b0, 4'd0,  4'd0,  8'hFF, 10'd247, 8'd0};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    click       = 1'b0;
    mouse_x     = '0;
    mouse_y     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("idle_after_reset");

    // spawn stagger: one new slot per frame
    for (int k = 0; k < 8; k++) begin
      run_frame(tbl[k].clk_in, tbl[k].mx, tbl[k].my, 1'b0, 1'b0);
      check($sformatf("stagger%0d_active", k), 80'(active), 80'(tbl[k].exp_active));
      check($sformatf("stagger%0d_y0", k), 80'(blossom_y[9:0]), 80'(tbl[k].exp_y0));
      check($sformatf("stagger%0d_hits", k), 80'(hit_count), 80'(tbl[k].exp_hit));
      if (k == 0) check("first_spawn_x0", 80'(blossom_x[9:0]), 80'(301));
    end

    for (int k = 0; k < 9; k++) run_frame(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("y0_before_hit", 80'(blossom_y[9:0]), 80'(256));

    // slot0 at x=301,y=256 lies in cell (9,8)
    run_frame(1'b1, 4'd9, 4'd8, 1'b0, 1'b0);
    check("hit_slot0_active", 80'(active[0]), 80'(0));
    check("hit_slot0_count", 80'(hit_count), 80'(1));
    run_frame(1'b0, 4'd9, 4'd8, 1'b0, 1'b0);
    check("no_click_count", 80'(hit_count), 80'(1));
    run_frame(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    check("miss_empty_cell", 80'(hit_count), 80'(1));

    // click edge during a busy pass belongs to the next frame
    cx = 4'(m_x[1] >> 5);
    cy = 4'((m_y[1] + 10'd1) >> 5);
    run_frame(1'b0, cx, cy, 1'b0, 1'b1);
    check("busy_click_deferred", 80'(hit_count), 80'(1));
    run_frame(1'b0, cx, cy, 1'b0, 1'b0);
    check("busy_click_consumed", 80'(hit_count >= 8'd2), 80'(1));

    run_frame(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

    // reset in the middle of a pass
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("midpass_busy_before_reset", 80'(busy), 80'(1));
    rst_n = 1'b0;
    #1;
    check_reset_state("midpass_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    check_reset_state("after_midpass_release");

    // fall and despawn of slot0
    for (int k = 1; k <= 240; k++) run_frame(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("fall_y0_479", 80'(blossom_y[9:0]), 80'(479));
    check("fall_active0", 80'(active[0]), 80'(1));
    run_frame(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("despawn_active0", 80'(active[0]), 80'(0));
    check("despawn_y0", 80'(blossom_y[9:0]), 80'(240));
    wait_f = 0;
    while (!active[0] && wait_f < 20) begin
      run_frame(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      wait_f++;
    end
    check("respawn_window", 80'(wait_f >= 1 && wait_f <= 16), 80'(1));

    // saturate the hit counter by clicking the spawn row
    f = 0;
    while (m_hits < 260 && f < 1500) begin
      run_frame(1'b1, (f % 2 == 0) ? 4'd9 : 4'd10, 4'd7, 1'b0, 1'b0);
      f++;
    end
    check("sat_reached_260", 80'(m_hits >= 260), 80'(1));
    check("sat_hit_count", 80'(hit_count), 80'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
